// File: rtl/uart_frame_gen_if.sv
// Control/status bundle of the UART frame generator: burst request fields in,
// serial line plus per-frame and per-burst status out.
interface uart_frame_gen_if #(
  parameter int DATA_BITS = 8,
  parameter int COUNT_W   = 17
);
  logic                 start;
  logic [COUNT_W-1:0]   count;
  logic                 mode;
  logic [15:0]          seed;
  logic                 tx;
  logic                 busy;
  logic                 done;
  logic                 byte_strobe;
  logic [DATA_BITS-1:0] byte_data;
  logic [COUNT_W-1:0]   sent_count;

  modport master (
    output start, count, mode, seed,
    input  tx, busy, done, byte_strobe, byte_data, sent_count
  );

  modport slave (
    input  start, count, mode, seed,
    output tx, busy, done, byte_strobe, byte_data, sent_count
  );
endinterface

// File: rtl/uart_frame_gen.sv
// Burst UART frame generator with LFSR or counting payload for on-chip loopback tests.
// Optional trailing XOR checksum frame enabled by defining UART_FRAME_GEN_CHECKSUM_EN.
module uart_frame_gen #(
  parameter int CLK_FREQ    = 27000000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int GAP_BITS    = 10,
  parameter int COUNT_W     = 17
) (
  input logic             clk,
  input logic             rst,
  uart_frame_gen_if.slave bus
);
  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP, S_FIN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           gap_cnt;
  logic [COUNT_W-1:0]   remaining;
  logic                 mode_q;
  logic [15:0]          lfsr;
  logic [DATA_BITS-1:0] word;
  logic [DATA_BITS-1:0] sh;
  logic                 tx_r, busy_r, done_r, strobe_r;
  logic [DATA_BITS-1:0] byte_data_r;
  logic [COUNT_W-1:0]   sent_r;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  logic                 bit_end;
  logic                 accept;
  logic                 frame_end;
  logic [15:0]          seed_eff;
  logic [DATA_BITS-1:0] first_word;
  logic [DATA_BITS-1:0] next_word;
  logic                 csum_pending;
  logic [DATA_BITS-1:0] csum_word;

  assign bit_end    = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign accept     = (state == S_IDLE) && bus.start && (bus.count != '0);
  assign seed_eff   = (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
  assign first_word = bus.mode ? bus.seed[DATA_BITS-1:0] : seed_eff[DATA_BITS-1:0];
  assign next_word  = mode_q ? word + DATA_BITS'(1) : lfsr[DATA_BITS-1:0];
  // A frame ends on the last gap bit, or on the last stop bit when there is no gap.
  assign frame_end  = bit_end &&
                      ((state == S_STOP && bit_idx == 3'(STOP_BITS - 1) && GAP_BITS == 0) ||
                       (state == S_GAP  && gap_cnt == 8'(GAP_BITS - 1)));

`ifdef UART_FRAME_GEN_CHECKSUM_EN
  logic [DATA_BITS-1:0] csum;
  logic                 in_csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_csum <= 1'b0;
    end else if (accept) begin
      csum    <= first_word;
      in_csum <= 1'b0;
    end else if (frame_end && remaining != '0) begin
      csum <= csum ^ next_word;
    end else if (frame_end && !in_csum) begin
      in_csum <= 1'b1;
    end
  end

  assign csum_pending = !in_csum;
  assign csum_word    = csum;
`else
  assign csum_pending = 1'b0;
  assign csum_word    = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      gap_cnt     <= '0;
      remaining   <= '0;
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      strobe_r    <= 1'b0;
      byte_data_r <= '0;
      sent_r      <= '0;
    end else begin
      done_r   <= 1'b0;
      strobe_r <= 1'b0;
      baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (bus.start) begin
            sent_r <= '0;
            if (bus.count == '0) begin
              done_r <= 1'b1;
            end else begin
              busy_r      <= 1'b1;
              mode_q      <= bus.mode;
              remaining   <= bus.count - COUNT_W'(1);
              word        <= first_word;
              lfsr        <= lfsr_step(seed_eff);
              state       <= S_START;
              tx_r        <= 1'b0;
              strobe_r    <= 1'b1;
              byte_data_r <= first_word;
              sent_r      <= COUNT_W'(1);
            end
          end
        end
        S_START: if (bit_end) begin
          state   <= S_DATA;
          bit_idx <= '0;
          tx_r    <= word[0];
          sh      <= word >> 1;
        end
        S_DATA: if (bit_end) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            bit_idx <= '0;
            if (PARITY_MODE != 0) begin
              state <= S_PARITY;
              tx_r  <= (PARITY_MODE == 1) ? ^word : ~^word;
            end else begin
              state <= S_STOP;
              tx_r  <= 1'b1;
            end
          end else begin
            bit_idx <= bit_idx + 3'd1;
            tx_r    <= sh[0];
            sh      <= sh >> 1;
          end
        end
        S_PARITY: if (bit_end) begin
          state   <= S_STOP;
          tx_r    <= 1'b1;
          bit_idx <= '0;
        end
        S_STOP: if (bit_end) begin
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            bit_idx <= '0;
            if (GAP_BITS != 0) begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
        S_GAP: if (bit_end) gap_cnt <= gap_cnt + 8'd1;
        S_FIN: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase

      if (frame_end) begin
        bit_idx <= '0;
        gap_cnt <= '0;
        if (remaining != '0) begin
          remaining   <= remaining - COUNT_W'(1);
          word        <= next_word;
          byte_data_r <= next_word;
          strobe_r    <= 1'b1;
          sent_r      <= sat_inc(sent_r);
          state       <= S_START;
          tx_r        <= 1'b0;
          if (!mode_q) lfsr <= lfsr_step(lfsr);
        end else if (csum_pending) begin
          word        <= csum_word;
          byte_data_r <= csum_word;
          strobe_r    <= 1'b1;
          state       <= S_START;
          tx_r        <= 1'b0;
        end else begin
          state  <= S_FIN;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
      end
    end
  end

  assign bus.tx          = tx_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.byte_strobe = strobe_r;
  assign bus.byte_data   = byte_data_r;
  assign bus.sent_count  = sent_r;
endmodule
